// File: rtl/sfp_module_supervisor.sv
// SFP+ cage supervisor: synchronises and debounces the module pins, sequences
// TX_DISABLE / RATE_SEL, and recovers from TX_FAULT with a bounded retry count.
module sfp_module_supervisor #(
    parameter int unsigned P_CLOCK_FREQUENCY = 125000000,
    parameter int unsigned P_DEBOUNCE_US     = 1000,
    parameter int unsigned P_TX_DISABLE_US   = 100,
    parameter int unsigned P_INIT_US         = 300000,
    parameter int unsigned P_FAULT_RETRY_MAX = 3
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_sfp_mod0_prsnt_n,
    input  logic       i_sfp_los,
    input  logic       i_sfp_tx_fault,
    input  logic       i_rate_10g,
    input  logic       i_fault_clear,
    output logic       o_sfp_tx_disable,
    output logic [1:0] o_sfp_rate_sel,
    output logic       o_xcvr_reset_n,
    output logic       o_module_present,
    output logic       o_link_up,
    output logic       o_fault_latched,
    output logic [3:0] o_retry_count
);

    localparam int unsigned TicksPerUs = P_CLOCK_FREQUENCY / 1000000;
    localparam int unsigned PrescW     = (TicksPerUs > 1) ? $clog2(TicksPerUs) : 1;
    localparam int unsigned MaxAB      = (P_INIT_US > P_DEBOUNCE_US) ? P_INIT_US : P_DEBOUNCE_US;
    localparam int unsigned TimerMaxUs = (MaxAB > P_TX_DISABLE_US) ? MaxAB : P_TX_DISABLE_US;
    localparam int unsigned TimerW     = $clog2(TimerMaxUs + 1);
    localparam int unsigned DebW       = $clog2(P_DEBOUNCE_US + 1);

    typedef enum logic [2:0] {
        StAbsent,
        StTxOff,
        StInit,
        StLosWait,
        StLinkUp,
        StRecover,
        StFault
    } state_e;

    state_e state_q, state_d;

    logic [1:0]        prsnt_sync_q, prsnt_sync_d;
    logic [1:0]        los_sync_q, los_sync_d;
    logic [1:0]        fault_sync_q, fault_sync_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [DebW-1:0]   prsnt_cnt_q, prsnt_cnt_d;
    logic [DebW-1:0]   los_cnt_q, los_cnt_d;
    logic              prsnt_acc_q, prsnt_acc_d;
    logic              los_acc_q, los_acc_d;
    logic [1:0]        rate_q, rate_d;
    logic [3:0]        retry_q, retry_d;
    logic              tx_disable_q, tx_disable_d;
    logic              xcvr_reset_n_q, xcvr_reset_n_d;
    logic              link_up_q, link_up_d;
    logic              fault_latched_q, fault_latched_d;

    logic us_tick;
    logic present;
    logic enter;
    logic tx_enabled;

    // Synchronisers, prescaler and debouncers
    always_comb begin
        prsnt_sync_d = {prsnt_sync_q[0], i_sfp_mod0_prsnt_n};
        los_sync_d   = {los_sync_q[0], i_sfp_los};
        fault_sync_d = {fault_sync_q[0], i_sfp_tx_fault};

        us_tick = (presc_q == PrescW'(TicksPerUs - 1));
        presc_d = us_tick ? '0 : presc_q + PrescW'(1);

        prsnt_acc_d = prsnt_acc_q;
        prsnt_cnt_d = prsnt_cnt_q;
        if (prsnt_sync_q[1] == prsnt_acc_q) begin
            prsnt_cnt_d = '0;
        end else if (prsnt_cnt_q == DebW'(P_DEBOUNCE_US)) begin
            prsnt_acc_d = prsnt_sync_q[1];
            prsnt_cnt_d = '0;
        end else if (us_tick) begin
            prsnt_cnt_d = prsnt_cnt_q + DebW'(1);
        end

        los_acc_d = los_acc_q;
        los_cnt_d = los_cnt_q;
        if (los_sync_q[1] == los_acc_q) begin
            los_cnt_d = '0;
        end else if (los_cnt_q == DebW'(P_DEBOUNCE_US)) begin
            los_acc_d = los_sync_q[1];
            los_cnt_d = '0;
        end else if (us_tick) begin
            los_cnt_d = los_cnt_q + DebW'(1);
        end
    end

    assign present = ~prsnt_acc_q;

    // Next-state logic; `enter` marks every state entry, including TX_OFF re-entry
    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        retry_d = retry_q;
        rate_d  = rate_q;

        if (!present) begin
            if (state_q != StAbsent) begin
                state_d = StAbsent;
                enter   = 1'b1;
            end
        end else if (state_q != StAbsent && state_q != StFault && i_rate_10g != rate_q[0]) begin
            state_d = StTxOff;
            enter   = 1'b1;
        end else begin
            unique case (state_q)
                StAbsent: begin
                    state_d = StTxOff;
                    enter   = 1'b1;
                end
                StTxOff: begin
                    if (timer_q >= TimerW'(P_TX_DISABLE_US)) begin
                        state_d = StInit;
                        enter   = 1'b1;
                    end
                end
                StInit: begin
                    if (timer_q >= TimerW'(P_INIT_US)) begin
                        enter = 1'b1;
                        if (fault_sync_q[1]) begin
                            state_d = StRecover;
                        end else begin
                            state_d = StLosWait;
                            retry_d = '0;
                        end
                    end
                end
                StLosWait: begin
                    if (!los_acc_q) begin
                        state_d = StLinkUp;
                        enter   = 1'b1;
                    end
                end
                StLinkUp: begin
                    if (los_acc_q) begin
                        state_d = StLosWait;
                        enter   = 1'b1;
                    end else if (fault_sync_q[1]) begin
                        state_d = StRecover;
                        enter   = 1'b1;
                    end
                end
                StRecover: begin
                    if (timer_q >= TimerW'(P_TX_DISABLE_US)) begin
                        enter   = 1'b1;
                        state_d = (retry_q >= 4'(P_FAULT_RETRY_MAX)) ? StFault : StInit;
                    end
                end
                StFault: begin
                    if (i_fault_clear) begin
                        state_d = StTxOff;
                        enter   = 1'b1;
                        retry_d = '0;
                    end
                end
                default: begin
                    state_d = StAbsent;
                    enter   = 1'b1;
                end
            endcase
        end

        if (enter && state_d == StTxOff) begin
            rate_d = {2{i_rate_10g}};
        end
        if (enter && state_d == StRecover && retry_q != 4'hF) begin
            retry_d = retry_q + 4'd1;
        end
        if (state_d == StAbsent) begin
            retry_d = '0;
        end

        if (enter) begin
            timer_d = '0;
        end else if (us_tick && timer_q != {TimerW{1'b1}}) begin
            timer_d = timer_q + TimerW'(1);
        end else begin
            timer_d = timer_q;
        end

        // Outputs follow the next state so they change on the same edge as the state
        tx_enabled      = (state_d == StInit) || (state_d == StLosWait) || (state_d == StLinkUp);
        tx_disable_d    = ~tx_enabled;
        xcvr_reset_n_d  = tx_enabled;
        link_up_d       = (state_d == StLinkUp);
        fault_latched_d = (state_d == StFault);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q         <= StAbsent;
            prsnt_sync_q    <= 2'b11;
            los_sync_q      <= 2'b11;
            fault_sync_q    <= 2'b00;
            presc_q         <= '0;
            timer_q         <= '0;
            prsnt_cnt_q     <= '0;
            los_cnt_q       <= '0;
            prsnt_acc_q     <= 1'b1;
            los_acc_q       <= 1'b1;
            rate_q          <= 2'b00;
            retry_q         <= '0;
            tx_disable_q    <= 1'b1;
            xcvr_reset_n_q  <= 1'b0;
            link_up_q       <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            prsnt_sync_q    <= prsnt_sync_d;
            los_sync_q      <= los_sync_d;
            fault_sync_q    <= fault_sync_d;
            presc_q         <= presc_d;
            timer_q         <= timer_d;
            prsnt_cnt_q     <= prsnt_cnt_d;
            los_cnt_q       <= los_cnt_d;
            prsnt_acc_q     <= prsnt_acc_d;
            los_acc_q       <= los_acc_d;
            rate_q          <= rate_d;
            retry_q         <= retry_d;
            tx_disable_q    <= tx_disable_d;
            xcvr_reset_n_q  <= xcvr_reset_n_d;
            link_up_q       <= link_up_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    assign o_sfp_tx_disable = tx_disable_q;
    assign o_sfp_rate_sel   = rate_q;
    assign o_xcvr_reset_n   = xcvr_reset_n_q;
    assign o_module_present = present;
    assign o_link_up        = link_up_q;
    assign o_fault_latched  = fault_latched_q;
    assign o_retry_count    = retry_q;

endmodule

// File: tb/tb_sfp_module_supervisor.sv
// Directed bench for sfp_module_supervisor at 4 clocks/us with short timings.
// A state held N us spans 4N-2..4N+1 clocks because the prescaler free-runs.
module tb_sfp_module_supervisor;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       prsnt_n = 1'b1;
    logic       los = 1'b1;
    logic       fault = 1'b0;
    logic       rate = 1'b1;
    logic       clear = 1'b0;
    logic       tx_disable;
    logic [1:0] rate_sel;
    logic       xcvr_reset_n;
    logic       present;
    logic       link_up;
    logic       fault_latched;
    logic [3:0] retry_count;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    sfp_module_supervisor #(
        .P_CLOCK_FREQUENCY(4000000),
        .P_DEBOUNCE_US    (2),
        .P_TX_DISABLE_US  (5),
        .P_INIT_US        (20),
        .P_FAULT_RETRY_MAX(3)
    ) dut (
        .i_clock           (clock),
        .i_reset_n         (reset_n),
        .i_sfp_mod0_prsnt_n(prsnt_n),
        .i_sfp_los         (los),
        .i_sfp_tx_fault    (fault),
        .i_rate_10g        (rate),
        .i_fault_clear     (clear),
        .o_sfp_tx_disable  (tx_disable),
        .o_sfp_rate_sel    (rate_sel),
        .o_xcvr_reset_n    (xcvr_reset_n),
        .o_module_present  (present),
        .o_link_up         (link_up),
        .o_fault_latched   (fault_latched),
        .o_retry_count     (retry_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic sig_val(input int which);
        case (which)
            0:       return present;
            1:       return tx_disable;
            2:       return link_up;
            3:       return fault_latched;
            default: return xcvr_reset_n;
        endcase
    endfunction

    // Sample on falling edges until the selected output reaches val or budget runs out
    task automatic wait_sig(input int which, input logic val, input int budget,
                            output int at, output bit ok);
        ok = 1'b0;
        at = cyc;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (sig_val(which) === val) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        prsnt_n = 1'b1;
        los     = 1'b1;
        fault   = 1'b0;
        rate    = 1'b1;
        clear   = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({tx_disable, rate_sel, xcvr_reset_n, present, link_up, fault_latched, retry_count}
            !== {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_values: got txd=%b rs=%b xr=%b pr=%b lu=%b fl=%b rc=%0d",
                     tx_disable, rate_sel, xcvr_reset_n, present, link_up, fault_latched,
                     retry_count);
        end
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        tests_run++;
        if (tx_disable !== 1'b1 || present !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_absent: txd=%b pr=%b, want txd=1 pr=0", tx_disable, present);
        end
    endtask

    task automatic test_insertion();
        int t0, tp, tf, tl;
        bit ok;
        do_reset();
        prsnt_n = 1'b0;
        los     = 1'b0;
        rate    = 1'b1;
        t0      = cyc;
        wait_sig(0, 1'b1, 100, tp, ok);
        tests_run++;
        if (!ok || tp - t0 < 8 || tp - t0 > 11) begin
            tests_failed++;
            $display("FAIL insert_present_delay: ok=%0d delay=%0d, want 8..11", ok, tp - t0);
        end
        wait_sig(1, 1'b0, 100, tf, ok);
        tests_run++;
        if (!ok || tf - tp < 19 || tf - tp > 22 || xcvr_reset_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL insert_tx_off_time: ok=%0d cycles=%0d xr=%b, want 19..22 xr=1",
                     ok, tf - tp, xcvr_reset_n);
        end
        wait_sig(2, 1'b1, 200, tl, ok);
        tests_run++;
        if (!ok || tl - tf < 79 || tl - tf > 82) begin
            tests_failed++;
            $display("FAIL insert_init_time: ok=%0d cycles=%0d, want 79..82", ok, tl - tf);
        end
        tests_run++;
        if (rate_sel !== 2'b11 || retry_count !== 4'd0 || tx_disable !== 1'b0) begin
            tests_failed++;
            $display("FAIL insert_linkup_outputs: rs=%b rc=%0d txd=%b, want 11 0 0",
                     rate_sel, retry_count, tx_disable);
        end
    endtask

    task automatic test_glitch();
        bit seen_present, seen_enable;
        do_reset();
        seen_present = 1'b0;
        seen_enable  = 1'b0;
        prsnt_n = 1'b0;
        repeat (4) @(negedge clock);
        prsnt_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (present === 1'b1) seen_present = 1'b1;
            if (tx_disable !== 1'b1) seen_enable = 1'b1;
        end
        tests_run++;
        if (seen_present || seen_enable) begin
            tests_failed++;
            $display("FAIL glitch_rejected: present_seen=%0d txd_low_seen=%0d, want 0 0",
                     seen_present, seen_enable);
        end
    endtask

    task automatic test_persistent_fault();
        int rises[3];
        int falls[3];
        logic [3:0] rc[3];
        int npulse, nfall, tfl;
        logic prev;
        bit seen_link, done;
        do_reset();
        fault = 1'b1;
        los   = 1'b0;
        prsnt_n = 1'b0;
        npulse = 0;
        nfall = 0;
        tfl = 0;
        seen_link = 1'b0;
        done = 1'b0;
        prev = tx_disable;
        for (int i = 0; i < 1500 && !done; i++) begin
            @(negedge clock);
            if (link_up === 1'b1) seen_link = 1'b1;
            if (prev === 1'b0 && tx_disable === 1'b1) begin
                if (npulse < 3) begin
                    rises[npulse] = cyc;
                    rc[npulse] = retry_count;
                end
                npulse++;
            end
            if (prev === 1'b1 && tx_disable === 1'b0 && npulse > 0 && nfall < 3) begin
                falls[nfall] = cyc;
                nfall++;
            end
            prev = tx_disable;
            if (fault_latched === 1'b1) begin
                done = 1'b1;
                tfl = cyc;
            end
        end
        tests_run++;
        if (!done || npulse != 3) begin
            tests_failed++;
            $display("FAIL fault_latch_pulses: latched=%0d pulses=%0d, want 1 3", done, npulse);
        end
        if (npulse == 3) begin
            tests_run++;
            if (rc[0] !== 4'd1 || rc[1] !== 4'd2 || rc[2] !== 4'd3) begin
                tests_failed++;
                $display("FAIL fault_retry_seq: got %0d %0d %0d, want 1 2 3", rc[0], rc[1], rc[2]);
            end
            tests_run++;
            if (nfall < 2 || falls[0] - rises[0] < 18 || falls[0] - rises[0] > 21 ||
                rises[1] - falls[0] < 78 || rises[1] - falls[0] > 81 ||
                tfl - rises[2] < 18 || tfl - rises[2] > 21) begin
                tests_failed++;
                $display("FAIL fault_timing: rec1=%0d init=%0d rec3=%0d, want 18..21 78..81 18..21",
                         falls[0] - rises[0], rises[1] - falls[0], tfl - rises[2]);
            end
        end
        tests_run++;
        if (seen_link || retry_count !== 4'd3 || xcvr_reset_n !== 1'b0 || tx_disable !== 1'b1) begin
            tests_failed++;
            $display("FAIL fault_state: link_seen=%0d rc=%0d xr=%b txd=%b, want 0 3 0 1",
                     seen_link, retry_count, xcvr_reset_n, tx_disable);
        end
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        tests_run++;
        if (fault_latched !== 1'b0 || retry_count !== 4'd0 || tx_disable !== 1'b1) begin
            tests_failed++;
            $display("FAIL fault_clear: fl=%b rc=%0d txd=%b, want 0 0 1",
                     fault_latched, retry_count, tx_disable);
        end
        fault = 1'b0;
    endtask

    task automatic test_transient_fault();
        int t;
        bit ok;
        do_reset();
        prsnt_n = 1'b0;
        los     = 1'b0;
        wait_sig(2, 1'b1, 400, t, ok);
        fault = 1'b1;
        @(negedge clock);
        fault = 1'b0;
        wait_sig(1, 1'b1, 10, t, ok);
        tests_run++;
        if (!ok || link_up !== 1'b0 || retry_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL transient_recover: ok=%0d lu=%b rc=%0d, want 1 0 1",
                     ok, link_up, retry_count);
        end
        wait_sig(1, 1'b0, 50, t, ok);
        tests_run++;
        if (!ok || retry_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL transient_init: ok=%0d rc=%0d, want 1 1", ok, retry_count);
        end
        wait_sig(2, 1'b1, 200, t, ok);
        tests_run++;
        if (!ok || retry_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL transient_relink: ok=%0d rc=%0d, want 1 0", ok, retry_count);
        end
    endtask

    task automatic test_los_drop();
        int t;
        bit ok;
        los = 1'b1;
        wait_sig(2, 1'b0, 30, t, ok);
        tests_run++;
        if (!ok || tx_disable !== 1'b0 || xcvr_reset_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL los_drop: ok=%0d txd=%b xr=%b, want 1 0 1", ok, tx_disable, xcvr_reset_n);
        end
        los = 1'b0;
        wait_sig(2, 1'b1, 30, t, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL los_return: link_up=%b, want 1", link_up);
        end
    endtask

    task automatic test_rate_change();
        int t0, tf, tl;
        bit ok;
        do_reset();
        prsnt_n = 1'b0;
        los     = 1'b0;
        rate    = 1'b1;
        wait_sig(2, 1'b1, 400, tl, ok);
        rate = 1'b0;
        @(negedge clock);
        t0 = cyc;
        tests_run++;
        if (link_up !== 1'b0 || tx_disable !== 1'b1 || rate_sel !== 2'b00 || xcvr_reset_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL rate_reseq: lu=%b txd=%b rs=%b xr=%b, want 0 1 00 0",
                     link_up, tx_disable, rate_sel, xcvr_reset_n);
        end
        wait_sig(1, 1'b0, 60, tf, ok);
        tests_run++;
        if (!ok || tf - t0 < 18 || tf - t0 > 21) begin
            tests_failed++;
            $display("FAIL rate_tx_off_time: ok=%0d cycles=%0d, want 18..21", ok, tf - t0);
        end
        wait_sig(2, 1'b1, 200, tl, ok);
        tests_run++;
        if (!ok || tl - tf < 79 || tl - tf > 82 || rate_sel !== 2'b00) begin
            tests_failed++;
            $display("FAIL rate_relink: ok=%0d cycles=%0d rs=%b, want 79..82 00",
                     ok, tl - tf, rate_sel);
        end
    endtask

    task automatic test_removal_reset();
        int t0, t;
        bit ok;
        do_reset();
        prsnt_n = 1'b0;
        los     = 1'b0;
        fault   = 1'b1;
        wait_sig(1, 1'b0, 100, t, ok);
        prsnt_n = 1'b1;
        t0 = cyc;
        wait_sig(0, 1'b0, 30, t, ok);
        tests_run++;
        if (!ok || t - t0 < 8 || t - t0 > 11) begin
            tests_failed++;
            $display("FAIL removal_delay: ok=%0d delay=%0d, want 8..11", ok, t - t0);
        end
        @(negedge clock);
        tests_run++;
        if (tx_disable !== 1'b1 || xcvr_reset_n !== 1'b0 || link_up !== 1'b0) begin
            tests_failed++;
            $display("FAIL removal_absent: txd=%b xr=%b lu=%b, want 1 0 0",
                     tx_disable, xcvr_reset_n, link_up);
        end
        prsnt_n = 1'b0;
        wait_sig(1, 1'b0, 100, t, ok);
        wait_sig(1, 1'b1, 200, t, ok);
        tests_run++;
        if (!ok || retry_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL reinsert_recover: ok=%0d rc=%0d, want 1 1", ok, retry_count);
        end
        repeat (3) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({tx_disable, rate_sel, xcvr_reset_n, present, link_up, fault_latched, retry_count}
            !== {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL async_reset: got txd=%b rs=%b xr=%b pr=%b lu=%b fl=%b rc=%0d",
                     tx_disable, rate_sel, xcvr_reset_n, present, link_up, fault_latched,
                     retry_count);
        end
        @(negedge clock);
        fault = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_insertion();
        test_glitch();
        test_persistent_fault();
        test_transient_fault();
        test_los_drop();
        test_rate_change();
        test_removal_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
